// File: rtl/core_config_pkg.sv
// core_config_pkg: core-wide widths, register/data types and operand-fetch states
package core_config_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   typedef logic [REG_ADDR_W-1:0] reg_idx_t;
   typedef logic [XLEN-1:0]       xword_t;
   typedef enum logic [1:0] {IDLE, READ, HOLD} of_state_t;
endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decode-side and execute-side handshakes of the operand fetch stage
interface operand_fetch_if
   import core_config_pkg::*;
#(
   parameter int TAG_W = 32
) ();
   logic             in_valid;
   logic             in_ready;
   reg_idx_t         in_rs1;
   reg_idx_t         in_rs2;
   logic             in_use1;
   logic             in_use2;
   reg_idx_t         in_rd;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   xword_t           out_op1;
   xword_t           out_op2;
   reg_idx_t         out_rd;
   logic [TAG_W-1:0] out_tag;
   modport master (
      output in_valid, in_rs1, in_rs2, in_use1, in_use2, in_rd, in_tag, out_ready,
      input  in_ready, out_valid, out_op1, out_op2, out_rd, out_tag
   );
   modport slave (
      input  in_valid, in_rs1, in_rs2, in_use1, in_use2, in_rd, in_tag, out_ready,
      output in_ready, out_valid, out_op1, out_op2, out_rd, out_tag
   );
endinterface

// File: rtl/operand_fetch_resolve.sv
// operand_resolve: priority mux picking one source operand (x0, EX forward, WB forward, stored)
module operand_resolve
   import core_config_pkg::*;
(
   input  reg_idx_t rs,
   input  logic     ex_valid,
   input  reg_idx_t ex_rd,
   input  logic     ex_data_ok,
   input  xword_t   ex_data,
   input  logic     wb_we,
   input  reg_idx_t wb_wa,
   input  xword_t   wb_wd,
   input  xword_t   stored,
   output xword_t   op
);
   assign op = (rs == '0) ? '0 :
               (ex_valid && ex_rd == rs && ex_data_ok) ? ex_data :
               (wb_we && wb_wa == rs) ? wb_wd : stored;
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: reads the register file, resolves forwarding/hazards, hands operands to execute
module operand_fetch
   import core_config_pkg::*;
#(
   parameter int TAG_W = 32
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     flush,
   operand_fetch_if.slave bus,
   output reg_idx_t rf_ra1,
   output reg_idx_t rf_ra2,
   input  xword_t   rf_rd1,
   input  xword_t   rf_rd2,
   input  logic     wb_we,
   input  reg_idx_t wb_wa,
   input  xword_t   wb_wd,
   input  logic     ex_valid,
   input  reg_idx_t ex_rd,
   input  logic     ex_data_ok,
   input  xword_t   ex_data
);
   of_state_t        state, state_n;
   reg_idx_t         rs1_q, rs2_q, rd_q;
   logic             use1_q, use2_q, hit1_q, hit2_q;
   xword_t           wbd1_q, wbd2_q, op1_q, op2_q;
   logic [TAG_W-1:0] tag_q;
   xword_t           st1, st2, res1, res2;
   logic             haz, fire, accept;

   assign rf_ra1      = bus.in_rs1;
   assign rf_ra2      = bus.in_rs2;
   assign bus.out_op1 = res1;
   assign bus.out_op2 = res2;
   assign bus.out_rd  = rd_q;
   assign bus.out_tag = tag_q;
   assign bus.out_valid = (state != IDLE) && !haz;
   assign bus.in_ready  = !flush && (state == IDLE || fire);

   operand_resolve u_res1 (
      .rs(rs1_q), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data_ok(ex_data_ok), .ex_data(ex_data),
      .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .stored(st1), .op(res1)
   );

   operand_resolve u_res2 (
      .rs(rs2_q), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data_ok(ex_data_ok), .ex_data(ex_data),
      .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .stored(st2), .op(res2)
   );

   // stored operand selection, load-use hazard and next state; the RF returns old data on a same-edge write, so the captured WB value wins in READ
   always_comb begin
      st1     = (state == READ) ? (hit1_q ? wbd1_q : rf_rd1) : op1_q;
      st2     = (state == READ) ? (hit2_q ? wbd2_q : rf_rd2) : op2_q;
      haz     = (use1_q && rs1_q != '0 && ex_valid && ex_rd == rs1_q && !ex_data_ok) ||
                (use2_q && rs2_q != '0 && ex_valid && ex_rd == rs2_q && !ex_data_ok);
      fire    = bus.out_valid && bus.out_ready;
      accept  = bus.in_valid && bus.in_ready;
      state_n = flush ? IDLE : accept ? READ : fire ? IDLE : (state == READ) ? HOLD : state;
   end

   // state register, accept-time capture of the entry, and operand holding while execute is not ready
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         rs1_q  <= '0;
         rs2_q  <= '0;
         use1_q <= 1'b0;
         use2_q <= 1'b0;
         rd_q   <= '0;
         tag_q  <= '0;
         hit1_q <= 1'b0;
         hit2_q <= 1'b0;
         wbd1_q <= '0;
         wbd2_q <= '0;
         op1_q  <= '0;
         op2_q  <= '0;
      end else begin
         state <= state_n;
         if (accept) begin
            rs1_q  <= bus.in_rs1;
            rs2_q  <= bus.in_rs2;
            use1_q <= bus.in_use1;
            use2_q <= bus.in_use2;
            rd_q   <= bus.in_rd;
            tag_q  <= bus.in_tag;
            hit1_q <= wb_we && wb_wa == bus.in_rs1;
            hit2_q <= wb_we && wb_wa == bus.in_rs2;
            wbd1_q <= wb_wd;
            wbd2_q <= wb_wd;
         end
         if (state == READ && !fire) begin
            op1_q <= res1;
            op2_q <= res2;
         end else if (state == HOLD && !fire) begin
            op1_q <= (wb_we && wb_wa == rs1_q && rs1_q != '0) ? wb_wd : op1_q;
            op2_q <= (wb_we && wb_wa == rs2_q && rs2_q != '0) ? wb_wd : op2_q;
         end
      end
   end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed vector table plus multi-cycle sequences for operand_fetch
module tb_operand_fetch;
   import core_config_pkg::*;

   typedef struct {
      logic [4:0]  rs1, rs2;
      logic        u1, u2, exv;
      logic [4:0]  exrd;
      logic        exok;
      logic [31:0] exd;
      logic        wbwe;
      logic [4:0]  wbwa;
      logic [31:0] wbwd;
      logic        ev;
      logic [31:0] e1, e2;
   } vec_t;

   logic     clk = 1'b0;
   logic     rst, flush, wb_we, ex_valid, ex_data_ok;
   reg_idx_t wb_wa, ex_rd, rf_ra1, rf_ra2;
   xword_t   wb_wd, ex_data, rf_rd1, rf_rd2;
   xword_t   regs [32];
   int       n_chk = 0;
   int       n_fail = 0;
   vec_t     vt [11];

   operand_fetch_if #(.TAG_W(32)) bus ();

   operand_fetch #(.TAG_W(32)) dut (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus),
      .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data_ok(ex_data_ok), .ex_data(ex_data)
   );

   always #5 clk = ~clk;

   // register file model: one-cycle read latency, old data on a same-edge write, x0 hardwired to 0
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'h0 : 32'h100 + 32'(i);
      end else if (wb_we && wb_wa != 5'd0) begin
         regs[wb_wa] <= wb_wd;
      end
      rf_rd1 <= (rf_ra1 == 5'd0) ? 32'h0 : regs[rf_ra1];
      rf_rd2 <= (rf_ra2 == 5'd0) ? 32'h0 : regs[rf_ra2];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      bus.in_valid = 1'b0;
      bus.in_use1  = 1'b1;
      bus.in_use2  = 1'b1;
      bus.out_ready = 1'b1;
      flush = 1'b0;
      wb_we = 1'b0;
      ex_valid = 1'b0;
      ex_data_ok = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] tag);
      bus.in_valid = 1'b1;
      bus.in_rs1 = rs1;
      bus.in_rs2 = rs2;
      bus.in_rd = rs1 + 5'd1;
      bus.in_tag = tag;
   endtask

   initial begin
      vt[0]  = '{5'd1,  5'd2,  1,1, 0,5'd0, 0,32'h0,        0,5'd0,32'h0,    1, 32'h101,  32'h102};
      vt[1]  = '{5'd3,  5'd4,  1,1, 1,5'd3, 1,32'hAAAA,     0,5'd0,32'h0,    1, 32'hAAAA, 32'h104};
      vt[2]  = '{5'd5,  5'd6,  1,1, 0,5'd0, 0,32'h0,        1,5'd6,32'hBBBB, 1, 32'h105,  32'hBBBB};
      vt[3]  = '{5'd8,  5'd9,  1,1, 1,5'd8, 1,32'hC1,       1,5'd8,32'hC2,   1, 32'hC1,   32'h109};
      vt[4]  = '{5'd0,  5'd0,  1,1, 1,5'd0, 0,32'hFFFFFFFF, 0,5'd0,32'h0,    1, 32'h0,    32'h0};
      vt[5]  = '{5'd0,  5'd10, 1,1, 1,5'd0, 1,32'hDEAD,     1,5'd0,32'h77,   1, 32'h0,    32'h10A};
      vt[6]  = '{5'd11, 5'd1,  1,1, 1,5'd11,0,32'h0,        0,5'd0,32'h0,    0, 32'h0,    32'h0};
      vt[7]  = '{5'd11, 5'd12, 0,1, 1,5'd11,0,32'h99,       0,5'd0,32'h0,    1, 32'h10B,  32'h10C};
      vt[8]  = '{5'd1,  5'd13, 1,1, 1,5'd13,0,32'h0,        0,5'd0,32'h0,    0, 32'h0,    32'h0};
      vt[9]  = '{5'd14, 5'd2,  1,1, 0,5'd14,1,32'h55,       0,5'd0,32'h0,    1, 32'h10E,  32'h102};
      vt[10] = '{5'd6,  5'd8,  1,1, 0,5'd0, 0,32'h0,        0,5'd0,32'h0,    1, 32'hBBBB, 32'hC2};
      quiet();
      bus.in_rs1 = '0;
      bus.in_rs2 = '0;
      bus.in_rd = '0;
      bus.in_tag = '0;
      wb_wa = '0;
      wb_wd = '0;
      ex_rd = '0;
      ex_data = '0;
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
      chk("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
      chk("rst_out_tag", bus.out_tag, 32'h0);
      chk("rst_out_rd", {27'b0, bus.out_rd}, 32'h0);
      chk("rst_out_op1", bus.out_op1, 32'h0);

      for (int i = 0; i < 11; i++) begin
         issue(vt[i].rs1, vt[i].rs2, 32'(i));
         bus.in_use1 = vt[i].u1;
         bus.in_use2 = vt[i].u2;
         step();
         bus.in_valid = 1'b0;
         ex_valid = vt[i].exv;
         ex_rd = vt[i].exrd;
         ex_data_ok = vt[i].exok;
         ex_data = vt[i].exd;
         wb_we = vt[i].wbwe;
         wb_wa = vt[i].wbwa;
         wb_wd = vt[i].wbwd;
         @(negedge clk);
         chk($sformatf("vec%0d_valid", i), {31'b0, bus.out_valid}, {31'b0, vt[i].ev});
         if (vt[i].ev) begin
            chk($sformatf("vec%0d_op1", i), bus.out_op1, vt[i].e1);
            chk($sformatf("vec%0d_op2", i), bus.out_op2, vt[i].e2);
         end
         step();
         quiet();
         step();
         step();
      end

      wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'h11;
      step();
      issue(5'd5, 5'd0, 32'hA0);
      wb_wd = 32'h22;
      step();
      quiet();
      @(negedge clk);
      chk("wbhit_valid", {31'b0, bus.out_valid}, 32'h1);
      chk("wbhit_op1", bus.out_op1, 32'h22);
      step();
      step();

      issue(5'd1, 5'd7, 32'hB0);
      step();
      bus.in_valid = 1'b0;
      ex_valid = 1'b1; ex_rd = 5'd7; ex_data_ok = 1'b0; ex_data = 32'h0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_valid", k), {31'b0, bus.out_valid}, 32'h0);
         step();
      end
      ex_data_ok = 1'b1; ex_data = 32'hABCD;
      @(negedge clk);
      chk("stall_release_valid", {31'b0, bus.out_valid}, 32'h1);
      chk("stall_release_op2", bus.out_op2, 32'hABCD);
      chk("stall_release_op1", bus.out_op1, 32'h101);
      chk("stall_release_tag", bus.out_tag, 32'hB0);
      step();
      quiet();
      @(negedge clk);
      chk("stall_done_valid", {31'b0, bus.out_valid}, 32'h0);

      bus.out_ready = 1'b0;
      issue(5'd3, 5'd0, 32'h33);
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("hold_c1_op1", bus.out_op1, 32'h103);
      step();
      wb_we = 1'b1; wb_wa = 5'd3; wb_wd = 32'h55;
      step();
      wb_we = 1'b0;
      for (int k = 3; k <= 5; k++) begin
         @(negedge clk);
         chk($sformatf("hold_c%0d_op1", k), bus.out_op1, 32'h55);
         chk($sformatf("hold_c%0d_tag", k), bus.out_tag, 32'h33);
         chk($sformatf("hold_c%0d_valid", k), {31'b0, bus.out_valid}, 32'h1);
         if (k < 5) step();
      end
      step();
      quiet();
      step();
      step();

      for (int i = 1; i <= 6; i++) begin
         issue(5'(i), 5'd0, 32'hD0 + 32'(i));
         step();
         @(negedge clk);
         chk($sformatf("stream%0d_valid", i), {31'b0, bus.out_valid}, 32'h1);
         chk($sformatf("stream%0d_tag", i), bus.out_tag, 32'hD0 + 32'(i));
         chk($sformatf("stream%0d_in_ready", i), {31'b0, bus.in_ready}, 32'h1);
      end
      bus.in_valid = 1'b0;
      step();
      @(negedge clk);
      chk("stream_end_valid", {31'b0, bus.out_valid}, 32'h0);

      bus.out_ready = 1'b0;
      issue(5'd1, 5'd2, 32'hE0);
      step();
      bus.in_valid = 1'b0;
      step();
      flush = 1'b1;
      issue(5'd2, 5'd1, 32'hE1);
      @(negedge clk);
      chk("flush_in_ready", {31'b0, bus.in_ready}, 32'h0);
      chk("flush_held_valid", {31'b0, bus.out_valid}, 32'h1);
      step();
      flush = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", {31'b0, bus.out_valid}, 32'h0);
      chk("flush_in_ready_after", {31'b0, bus.in_ready}, 32'h1);
      step();

      issue(5'd1, 5'd2, 32'hF0);
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("rstread_tag", bus.out_tag, 32'hF0);
      rst = 1'b1;
      step();
      @(negedge clk);
      chk("rstread_valid", {31'b0, bus.out_valid}, 32'h0);
      chk("rstread_tag0", bus.out_tag, 32'h0);
      chk("rstread_rd0", {27'b0, bus.out_rd}, 32'h0);
      chk("rstread_op1", bus.out_op1, 32'h0);
      chk("rstread_op2", bus.out_op2, 32'h0);
      rst = 1'b0;
      step();
      @(negedge clk);
      chk("rstread_in_ready", {31'b0, bus.in_ready}, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-side stage directly upstream of the register file: accepts one decoded instruction per cycle, drives the two read addresses, captures the 1-cycle-latency read data and resolves operands.
- Resolves operands against the write-back port and the EX-stage result, detects load-use hazards, and presents resolved operands to the execute stage over a valid/ready handshake.
- Closes the register-file gap where a write and a read of the same register on one clock edge returns the old value.

Parameters:
- TAG_W, 32, width of the opaque payload (PC plus decoded control) carried alongside the operands.
- XLEN and REG_ADDR_W are imported from core_config_pkg, not local parameters.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  drop held entry (branch redirect).
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage can accept this cycle.
- in_rs1, in_rs2  in  REG_ADDR_W  source register indices.
- in_use1, in_use2  in  1  source actually used (gates hazard detection).
- in_rd  in  REG_ADDR_W  destination index, passed through.
- in_tag  in  TAG_W  payload, passed through.
- rf_ra1, rf_ra2  out  REG_ADDR_W  register-file read addresses.
- rf_rd1, rf_rd2  in  XLEN  register-file read data, valid the cycle after address.
- wb_we, wb_wa, wb_wd  in  1/REG_ADDR_W/XLEN  snoop of the register-file write port.
- ex_valid  in  1  EX stage holds an instruction writing ex_rd.
- ex_rd  in  REG_ADDR_W  EX destination.
- ex_data_ok  in  1  ex_data is final (0 for a load still in flight).
- ex_data  in  XLEN  EX result.
- out_valid, out_ready  out/in  1  handshake to execute.
- out_op1, out_op2  out  XLEN  resolved operands.
- out_rd, out_tag  out  REG_ADDR_W/TAG_W  passthrough.

Behaviour:
- State machine IDLE, READ, HOLD.
  - IDLE: empty.
  - READ: first cycle after accept; stored operand is rf_rdX, replaced by wb_wd if a write-port hit occurred in the accept cycle (hit flag and data registered at accept).
  - HOLD: operands held in internal op1/op2 registers.
- Definitions: accept = in_valid & in_ready; fire = out_valid & out_ready.
- in_ready = !flush & (state==IDLE | fire). Combinational from out_ready.
- rf_raX = in_rsX every cycle. Only the value sampled on an accept cycle is used.
- Transitions:
  - accept → READ, including back-to-back accept with fire.
  - READ or HOLD with fire and no accept → IDLE.
  - READ without fire → HOLD: latch resolved operands.
  - HOLD without fire: latch wb_wd into opX when wb_we & wb_wa==rsX & rsX!=0.
  - flush → IDLE from any state, overriding accept and fire.
- Operand resolution, per source, highest priority first:
  1. rsX==0 → 0. Never forwarded, never a hazard.
  2. ex_valid & ex_rd==rsX & ex_data_ok → ex_data.
  3. wb_we & wb_wa==rsX → wb_wd (same-cycle write-back).
  4. Stored value.
- Hazard: useX & rsX!=0 & ex_valid & ex_rd==rsX & !ex_data_ok.
  - out_valid = (state!=IDLE) & !hazard.
  - While stalled, the entry stays held and snooping continues.
- out_rd and out_tag are registered at accept and stable while held.
- Reset: state IDLE; out_valid=0; op1, op2, out_rd, out_tag, wb hit flags cleared to 0. in_ready is 1 from the first cycle after reset release.
- Outputs are stable while out_valid & !out_ready, except out_opX, which may change only through EX/WB forwarding of a newer value to the same register.

Decomposition:
- Add to core_config_pkg: typedef reg_idx_t (REG_ADDR_W bits), typedef xword_t (XLEN bits), and an of_state_t enum (IDLE, READ, HOLD).
- One natural sub-module, operand_resolve: a combinational priority mux for one source, instantiated twice.

Test Plan:
- Directed scenarios:
  - Regfile x5=0x11. Accept rs1=5 with wb write x5=0x22 in the same cycle → READ cycle out_op1=0x22, not 0x11.
  - rs1=0, ex_rd=0, ex_data=0xFFFF_FFFF, ex_data_ok=0 → out_op1=0, out_valid=1, no stall.
  - EX load to x7 with ex_data_ok=0 for 3 cycles, consumer rs2=7, use2=1 → out_valid=0 for 3 cycles. Then ex_data_ok=1, ex_data=0xABCD → out_op2=0xABCD, out_valid=1.
  - out_ready=0 for 5 cycles, wb writes x3=0x55 in cycle 2 while rs1=3 is held → out_op1=0x55 from cycle 3 onward; out_tag unchanged.
  - Continuous in_valid and out_ready=1 → one fire per cycle, tags in order, no bubbles.
  - flush in HOLD with in_valid=1 → next cycle IDLE, out_valid=0, in_ready=1.
- Also: rst asserted in READ → next cycle out_valid=0, and all registers listed under Reset read 0.
